// File: rtl/iob_uart_rx_fifo.sv
// iob_uart_rx_fifo
// ----------------
// Serial receive front-end for the tester's rs232 link. Deserializes UART
// frames arriving on rxd_i into bytes, buffers them in a first-word-fall-through
// FIFO, presents them as a valid/ready byte stream and drives rts_o hardware
// flow control from the FIFO fill level.
//
// Configuration macro: IOB_UART_RX_PARITY_EN
//   defined   -> 8E1 frames (start, 8 data LSB first, even parity, stop);
//                parity mismatches set parity_err_o and drop the byte.
//   undefined -> 8N1 frames; no parity logic is built, parity_err_o is 0.
//
// Parameters
//   FREQ        clock frequency in Hz
//   BAUD        line rate; DIV = FREQ/BAUD clocks per bit (DIV >= 4)
//   FIFO_AW     FIFO address width, depth = 2**FIFO_AW bytes
//   RTS_MARGIN  rts_o drops when level_o >= depth - RTS_MARGIN
//
// Ports
//   clk_i          in   system clock
//   rst_i          in   synchronous reset, active-high
//   rxd_i          in   asynchronous serial input, idle high
//   rts_o          out  1 = peer may send, 0 = FIFO near full (registered)
//   data_o         out  head-of-FIFO byte, valid when valid_o = 1 (0 when empty)
//   valid_o        out  FIFO not empty
//   ready_i        in   consumer accepts data_o when valid_o & ready_i
//   level_o        out  bytes currently held (0..depth)
//   frame_err_o    out  sticky: stop bit sampled 0
//   overrun_err_o  out  sticky: byte arrived while FIFO full with no same-cycle pop
//   parity_err_o   out  sticky: parity mismatch
//   err_clr_i      in   clears all sticky error flags (a same-cycle set wins)

module iob_uart_rx_fifo #(
  parameter int FREQ       = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_AW    = 4,
  parameter int RTS_MARGIN = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rxd_i,
  output logic               rts_o,
  output logic [7:0]         data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [FIFO_AW:0]   level_o,
  output logic               frame_err_o,
  output logic               overrun_err_o,
  output logic               parity_err_o,
  input  logic               err_clr_i
);

  localparam int DIV   = FREQ / BAUD;
  localparam int CW    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;

  localparam logic [CW-1:0] FULL_RELOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(DIV / 2 - 1);
  localparam logic [LW-1:0] DEPTH_LVL   = LW'(DEPTH);
  localparam logic [LW-1:0] RTS_LVL     = LW'(DEPTH - RTS_MARGIN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef IOB_UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer; resets to the idle line level so a reset never looks
  // like a start bit.
  // ---------------------------------------------------------------------------
  logic rxd_meta;
  logic rxd_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd_i;
      rxd_s    <= rxd_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM state and datapath registers
  // ---------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           tick;
  logic           push_req;
  logic           frame_set;
`ifdef IOB_UART_RX_PARITY_EN
  logic           par_mis_q, par_mis_d;
  logic           parity_set;
`endif

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef IOB_UART_RX_PARITY_EN
      par_mis_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef IOB_UART_RX_PARITY_EN
      par_mis_q <= par_mis_d;
`endif
    end
  end

  // The start bit is re-checked half a bit time after the falling edge, so
  // every later sample lands near the middle of its bit. STOP returns to IDLE
  // on the very cycle it samples, leaving the FSM ready for a back-to-back
  // start edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef IOB_UART_RX_PARITY_EN
    par_mis_d  = par_mis_q;
    parity_set = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d = S_START;
          cnt_d   = HALF_RELOAD;
        end
      end

      S_START: begin
        if (tick) begin
          if (!rxd_s) begin
            state_d   = S_DATA;
            cnt_d     = FULL_RELOAD;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d[bit_idx_q] = rxd_s;
          cnt_d              = FULL_RELOAD;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef IOB_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

`ifdef IOB_UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          // Even parity: the parity bit equals the XOR of the data bits.
          par_mis_d = rxd_s ^ (^shift_q);
          cnt_d     = FULL_RELOAD;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          state_d   = S_IDLE;
          frame_set = !rxd_s;
`ifdef IOB_UART_RX_PARITY_EN
          parity_set = par_mis_q;
          push_req   = rxd_s && !par_mis_q;
`else
          push_req   = rxd_s;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO. A push while full only succeeds if the head leaves in the same cycle;
  // in that case the write lands on the slot being vacated.
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [LW-1:0]      level_q;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic               overrun_set;

  assign full        = (level_q == DEPTH_LVL);
  assign valid_o     = (level_q != '0);
  assign pop         = valid_o && ready_i;
  assign push_ok     = push_req && (!full || pop);
  assign overrun_set = push_req && full && !pop;

  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      if (push_ok && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push_ok) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // Empty FIFO presents 0 so data_o never shows stale or uninitialised slots.
  assign data_o  = valid_o ? mem[rd_ptr_q] : 8'h00;
  assign level_o = level_q;

  // ---------------------------------------------------------------------------
  // Flow control, registered from the current fill level.
  // ---------------------------------------------------------------------------
  logic rts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rts_q <= 1'b1;
    end else begin
      rts_q <= (level_q < RTS_LVL);
    end
  end

  assign rts_o = rts_q;

  // ---------------------------------------------------------------------------
  // Sticky error flags; a set in the same cycle as err_clr_i wins.
  // ---------------------------------------------------------------------------
  logic frame_err_q;
  logic overrun_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= frame_set   || (frame_err_q   && !err_clr_i);
      overrun_err_q <= overrun_set || (overrun_err_q && !err_clr_i);
    end
  end

  assign frame_err_o   = frame_err_q;
  assign overrun_err_o = overrun_err_q;

`ifdef IOB_UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_set || (parity_err_q && !err_clr_i);
    end
  end

  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_uart_rx_fifo.sv
// Testbench for iob_uart_rx_fifo (FREQ=1 MHz, BAUD=100 kHz -> 10 clocks/bit,
// depth 4, RTS_MARGIN 1). A queue-based model tracks the expected FIFO
// contents, fill level, rts and sticky flags; every cycle the DUT outputs are
// compared against it on the falling clock edge.

module tb_iob_uart_rx_fifo;

  localparam int FREQ       = 1000000;
  localparam int BAUD       = 100000;
  localparam int FIFO_AW    = 2;
  localparam int RTS_MARGIN = 1;
  localparam int DIV        = FREQ / BAUD;
  localparam int DEPTH      = 1 << FIFO_AW;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             rxd_i;
  logic             rts_o;
  logic [7:0]       data_o;
  logic             valid_o;
  logic             ready_i;
  logic [FIFO_AW:0] level_o;
  logic             frame_err_o;
  logic             overrun_err_o;
  logic             parity_err_o;
  logic             err_clr_i;

  iob_uart_rx_fifo #(
    .FREQ       (FREQ),
    .BAUD       (BAUD),
    .FIFO_AW    (FIFO_AW),
    .RTS_MARGIN (RTS_MARGIN)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rxd_i         (rxd_i),
    .rts_o         (rts_o),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .level_o       (level_o),
    .frame_err_o   (frame_err_o),
    .overrun_err_o (overrun_err_o),
    .parity_err_o  (parity_err_o),
    .err_clr_i     (err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  bit         exp_frame;
  bit         exp_overrun;
  bit         exp_parity;
  int         prev_level;
  bit         push_pend;
  logic [7:0] push_byte;
  bit         frame_pend;
  bit         parity_pend;
  bit         rand_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("valid", 32'(valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("data", 32'(data_o), 32'(exp_q[0]));
    check("level", 32'(level_o), 32'(exp_q.size()));
    check("rts", 32'(rts_o), 32'(prev_level < DEPTH - RTS_MARGIN));
    check("frame_err", 32'(frame_err_o), 32'(exp_frame));
    check("overrun_err", 32'(overrun_err_o), 32'(exp_overrun));
    check("parity_err", 32'(parity_err_o), 32'(exp_parity));
  endtask

  // One clock: update the model for the coming rising edge using the inputs
  // currently applied, then compare on the falling edge.
  task automatic tick();
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
    prev_level = exp_q.size();
    if (rst_i) begin
      exp_q.delete();
      exp_frame   = 1'b0;
      exp_overrun = 1'b0;
      exp_parity  = 1'b0;
      prev_level  = 0;
    end else begin
      if (err_clr_i) begin
        exp_frame   = 1'b0;
        exp_overrun = 1'b0;
        exp_parity  = 1'b0;
      end
      if (ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
      if (push_pend) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(push_byte);
        else exp_overrun = 1'b1;
      end
      if (frame_pend)  exp_frame  = 1'b1;
      if (parity_pend) exp_parity = 1'b1;
    end
    push_pend   = 1'b0;
    frame_pend  = 1'b0;
    parity_pend = 1'b0;
    @(negedge clk_i);
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Sends one frame. The byte is sampled on the stop bit's 8th clock (two
  // synchronizer stages plus mid-bit sampling), so that is where the model
  // receives the push/error event. pop_at_push raises ready_i for exactly that
  // clock only.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_bit,
                               input bit par_bit, input bit pop_at_push);
    bit bad_par;
    rxd_i = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      repeat (DIV) tick();
    end
`ifdef IOB_UART_RX_PARITY_EN
    rxd_i = par_bit;
    repeat (DIV) tick();
    bad_par = (par_bit != (^b));
`else
    bad_par = 1'b0;
`endif
    rxd_i = stop_bit;
    for (int c = 0; c < DIV; c++) begin
      if (c == 7) begin
        push_pend   = stop_bit && !bad_par;
        push_byte   = b;
        frame_pend  = !stop_bit;
        parity_pend = bad_par;
        if (pop_at_push) ready_i = 1'b1;
      end
      tick();
      if (c == 7 && pop_at_push) ready_i = 1'b0;
    end
    rxd_i = 1'b1;
  endtask

  task automatic pulseClear();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    bit         stop;

    rst_i       = 1'b1;
    rxd_i       = 1'b1;
    ready_i     = 1'b0;
    err_clr_i   = 1'b0;
    exp_frame   = 1'b0;
    exp_overrun = 1'b0;
    exp_parity  = 1'b0;
    prev_level  = 0;
    push_pend   = 1'b0;
    push_byte   = 8'h00;
    frame_pend  = 1'b0;
    parity_pend = 1'b0;
    rand_ready  = 1'b0;

    $display("[TB] reset");
    idle(3);
    check("reset_data", 32'(data_o), 32'h0);
    rst_i = 1'b0;
    idle(5);

    $display("[TB] single byte 0xA5 with ready");
    ready_i = 1'b1;
    b = 8'hA5;
    applyStimulus(b, 1'b1, ^b, 1'b0);
    idle(5);

    $display("[TB] short start glitch");
    rxd_i = 1'b0;
    idle(3);
    rxd_i = 1'b1;
    idle(15);

    $display("[TB] frame error on 0x3C");
    b = 8'h3C;
    applyStimulus(b, 1'b0, ^b, 1'b0);
    idle(15);
    pulseClear();
    idle(3);

    $display("[TB] back-to-back 0x01..0x05 with ready low");
    ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      applyStimulus(b, 1'b1, ^b, 1'b0);
    end
    idle(5);
    ready_i = 1'b1;
    idle(8);
    pulseClear();

    $display("[TB] push into full FIFO with same-cycle pop");
    ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      applyStimulus(b, 1'b1, ^b, 1'b0);
    end
    b = 8'($urandom);
    applyStimulus(b, 1'b1, ^b, 1'b1);
    idle(3);
    ready_i = 1'b1;
    idle(8);

    $display("[TB] reset in the middle of a frame");
    ready_i = 1'b0;
    b = 8'h55;
    applyStimulus(b, 1'b1, ^b, 1'b0);
    rxd_i = 1'b0;
    idle(DIV);
    rxd_i = 1'b1;
    idle(DIV);
    rxd_i = 1'b0;
    idle(DIV);
    rst_i = 1'b1;
    rxd_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    idle(20);
    ready_i = 1'b1;
    b = 8'h7E;
    applyStimulus(b, 1'b1, ^b, 1'b0);
    idle(5);

    $display("[TB] random frames with random ready");
    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      applyStimulus(b, stop, ^b, 1'b0);
      if (!stop) idle(15);
      idle(int'($urandom_range(0, 12)));
    end
    rand_ready = 1'b0;
    ready_i    = 1'b1;
    idle(10);
    pulseClear();

`ifdef IOB_UART_RX_PARITY_EN
    $display("[TB] parity checks on 0x07");
    b = 8'h07;
    applyStimulus(b, 1'b1, 1'b0, 1'b0);
    idle(5);
    applyStimulus(b, 1'b1, 1'b1, 1'b0);
    idle(5);
    pulseClear();
    idle(3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
